// File: rtl/adc_sample_averager.sv
// Boxcar averager for single-cycle-valid ADC samples.
// Emits one truncated mean per 2**LOG2_AVG samples of one channel.
module adc_sample_averager #(
    parameter int DATA_W   = 12,
    parameter int LOG2_AVG = 3
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              Temp_LDR_i,
    input  logic              Data_Available_i,
    input  logic [DATA_W-1:0] Data_i,
    output logic              Data_Available_o,
    output logic [DATA_W-1:0] Data_o,
    output logic              Channel_o,
    output logic [LOG2_AVG:0] Fill_o
);

    localparam int ACC_W  = DATA_W + LOG2_AVG;
    localparam int FILL_W = LOG2_AVG + 1;
    localparam logic [FILL_W-1:0] LAST_FILL =
        FILL_W'((1 << LOG2_AVG) - 1);

    logic              ch_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_sum;
    logic [FILL_W-1:0] fill_q;
    logic              chg;
    logic              accept;
    logic              last;
    logic [DATA_W-1:0] data_q;
    logic              chan_q;
    logic              dav_q;

    // Change detection, sample qualification and running sum.
    always_comb begin
        chg     = (Temp_LDR_i != ch_q);
        accept  = Data_Available_i && !chg;
        last    = (fill_q == LAST_FILL);
        acc_sum = acc_q + ACC_W'(Data_i);
    end

    // Channel register follows the select every cycle.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            ch_q <= 1'b0;
        end else begin
            ch_q <= Temp_LDR_i;
        end
    end

    // Window accumulator: cleared on reset, channel change or window end.
    always_ff @(posedge Clk_i) begin
        if (Reset_i || chg || (accept && last)) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else if (accept) begin
            acc_q  <= acc_sum;
            fill_q <= fill_q + FILL_W'(1);
        end
    end

    // Result register: loads the mean and pulses valid at window end.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            data_q <= '0;
            chan_q <= 1'b0;
            dav_q  <= 1'b0;
        end else begin
            dav_q <= 1'b0;
            if (accept && last) begin
                data_q <= acc_sum[ACC_W-1:LOG2_AVG];
                chan_q <= ch_q;
                dav_q  <= 1'b1;
            end
        end
    end

    assign Data_Available_o = dav_q;
    assign Data_o           = data_q;
    assign Channel_o        = chan_q;
    assign Fill_o           = fill_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager.
// Covers an 8-sample build and a LOG2_AVG=0 build side by side.
module tb_adc_sample_averager;

    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] d;
        logic          c;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel, dav_i;
    logic [DW-1:0] din;
    logic          dav_o, chan;
    logic [DW-1:0] dout;
    logic [3:0]    fill;

    logic          b_sel, b_dav_i;
    logic [DW-1:0] b_din;
    logic          b_dav_o, b_chan;
    logic [DW-1:0] b_dout;
    logic [0:0]    b_fill;

    exp_t exp_q[$];
    exp_t exp0_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   b_pulses = 0;

    always #5 clk = ~clk;

    adc_sample_averager #(.DATA_W(DW), .LOG2_AVG(3)) dut (
        .Clk_i(clk), .Reset_i(rst), .Temp_LDR_i(sel),
        .Data_Available_i(dav_i), .Data_i(din),
        .Data_Available_o(dav_o), .Data_o(dout),
        .Channel_o(chan), .Fill_o(fill)
    );

    adc_sample_averager #(.DATA_W(DW), .LOG2_AVG(0)) dut0 (
        .Clk_i(clk), .Reset_i(rst), .Temp_LDR_i(b_sel),
        .Data_Available_i(b_dav_i), .Data_i(b_din),
        .Data_Available_o(b_dav_o), .Data_o(b_dout),
        .Channel_o(b_chan), .Fill_o(b_fill)
    );

    // Cycle counter used to tag expected output timing.
    always @(posedge clk) cyc <= cyc + 1;

    // Pop and compare every averaged output of the 8-sample build.
    always @(negedge clk) begin
        exp_t e;
        if (dav_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got d=%0d c=%0d cyc=%0d",
                         dout, chan, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({dout, chan} !== {e.d, e.c} || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL avg_out got d=%0d c=%0d cyc=%0d exp d=%0d c=%0d cyc=%0d",
                             dout, chan, cyc, e.d, e.c, e.cyc);
                end
            end
        end
    end

    // Pop and compare every output of the pass-through build.
    always @(negedge clk) begin
        exp_t e;
        if (b_dav_o === 1'b1) begin
            total++;
            b_pulses++;
            if (exp0_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out0 got d=%0d cyc=%0d", b_dout, cyc);
            end else begin
                e = exp0_q.pop_front();
                if ({b_dout, b_chan} !== {e.d, e.c} || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL pass_out got d=%0d c=%0d cyc=%0d exp d=%0d c=%0d cyc=%0d",
                             b_dout, b_chan, cyc, e.d, e.c, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ch, input logic [DW-1:0] d,
                         input bit lst, input logic [DW-1:0] ed,
                         input logic ec);
        sel   = ch;
        dav_i = 1'b1;
        din   = d;
        if (lst) exp_q.push_back('{ed, ec, cyc + 1});
        step();
        dav_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({dav_o, dout, chan, fill} !== '0) begin
            bad++;
            $display("FAIL reset_vals got dav=%0b d=%0d c=%0b f=%0d exp 0",
                     dav_o, dout, chan, fill);
        end
        total++;
        if ({b_dav_o, b_dout, b_chan, b_fill} !== '0) begin
            bad++;
            $display("FAIL reset_vals0 got dav=%0b d=%0d c=%0b f=%0d exp 0",
                     b_dav_o, b_dout, b_chan, b_fill);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_constant();
        for (int i = 0; i < 8; i++) pulse(1'b0, 12'd100, i == 7, 12'd100, 1'b0);
        step();
        step();
        step();
        total++;
        if ({dout, chan} !== {12'd100, 1'b0}) begin
            bad++;
            $display("FAIL hold_idle got d=%0d c=%0b exp d=100 c=0", dout, chan);
        end
    endtask

    task automatic test_ramp();
        logic [3:0] ef;
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0, DW'(i), i == 7, 12'd3, 1'b0);
            ef = (i == 7) ? 4'd0 : 4'(i + 1);
            total++;
            if (fill !== ef) begin
                bad++;
                $display("FAIL fill_step%0d got %0d exp %0d", i, fill, ef);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++)
            pulse(1'b0, 12'd4095, i == 7 || i == 15, 12'd4095, 1'b0);
        step();
    endtask

    task automatic test_channel();
        for (int i = 0; i < 5; i++) pulse(1'b0, 12'd50, 1'b0, '0, 1'b0);
        total++;
        if (fill !== 4'd5) begin
            bad++;
            $display("FAIL fill_pre_chg got %0d exp 5", fill);
        end
        pulse(1'b1, 12'd50, 1'b0, '0, 1'b0);
        total++;
        if ({fill, dout, chan} !== {4'd0, 12'd4095, 1'b0}) begin
            bad++;
            $display("FAIL chg_cycle got f=%0d d=%0d c=%0b exp f=0 d=4095 c=0",
                     fill, dout, chan);
        end
        for (int i = 0; i < 8; i++) pulse(1'b1, 12'd200, i == 7, 12'd200, 1'b1);
        step();
        total++;
        if ({dout, chan} !== {12'd200, 1'b1}) begin
            bad++;
            $display("FAIL hold_ch1 got d=%0d c=%0b exp d=200 c=1", dout, chan);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        step();
        for (int i = 0; i < 4; i++) pulse(1'b0, 12'd999, 1'b0, '0, 1'b0);
        total++;
        if (fill !== 4'd4) begin
            bad++;
            $display("FAIL fill_pre_rst got %0d exp 4", fill);
        end
        rst = 1'b1;
        step();
        total++;
        if ({dav_o, dout, chan, fill} !== '0) begin
            bad++;
            $display("FAIL in_rst got dav=%0b d=%0d c=%0b f=%0d exp 0",
                     dav_o, dout, chan, fill);
        end
        rst = 1'b0;
        step();
        total++;
        if ({dav_o, dout, chan, fill} !== '0) begin
            bad++;
            $display("FAIL post_rst got dav=%0b d=%0d c=%0b f=%0d exp 0",
                     dav_o, dout, chan, fill);
        end
        for (int i = 0; i < 8; i++) pulse(1'b0, 12'd10, i == 7, 12'd10, 1'b0);
        step();
    endtask

    task automatic test_l2_zero();
        int vals[3] = '{7, 8, 9};
        b_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_dav_i = 1'b1;
            b_din   = DW'(vals[i]);
            exp0_q.push_back('{DW'(vals[i]), 1'b0, cyc + 1});
            step();
        end
        b_dav_i = 1'b0;
        step();
        step();
        total++;
        if (b_pulses !== 3) begin
            bad++;
            $display("FAIL pass_pulses got %0d exp 3", b_pulses);
        end
    endtask

    initial begin
        rst     = 1'b1;
        sel     = 1'b0;
        dav_i   = 1'b0;
        din     = '0;
        b_sel   = 1'b0;
        b_dav_i = 1'b0;
        b_din   = '0;
        #1;
        test_reset();
        test_constant();
        test_ramp();
        test_back_to_back();
        test_channel();
        test_reset_mid();
        test_l2_zero();
        step();
        step();
        total++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            bad++;
            $display("FAIL missing_out got pending=%0d/%0d exp 0/0",
                     exp_q.size(), exp0_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
